// File: rtl/tm1638_tx.sv
// TM1638 LED&KEY transmitter: encodes two BCD digits to 7-segment and sends the
// full write frame (data command, 16-byte display RAM, display control) on change.
module tm1638_tx #(
  parameter int unsigned CLK_DIV = 50,
  parameter logic [2:0]  BRIGHT  = 3'd7
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [3:0] dig_hi,
  input  logic [3:0] dig_lo,
  output logic       tm_stb,
  output logic       tm_clk,
  output logic       tm_dio,
  output logic       busy
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StStbLo   = 3'd1;
  localparam logic [2:0] StShiftLo = 3'd2;
  localparam logic [2:0] StShiftHi = 3'd3;
  localparam logic [2:0] StStbHi   = 3'd4;
  localparam logic [2:0] StGap     = 3'd5;

  localparam int unsigned    TickW   = 10;
  localparam logic [TickW-1:0] TickMax = TickW'(CLK_DIV - 1);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h40;
    endcase
    return s;
  endfunction

  // T2 byte 0 is the address command; display RAM addr N is byte N+1.
  function automatic logic [7:0] frame_byte(input logic [1:0] txn, input logic [4:0] idx,
                                            input logic [7:0] snap);
    logic [7:0] b;
    b = 8'h00;
    if (txn == 2'd0) begin
      b = 8'h40;
    end else if (txn == 2'd2) begin
      b = {5'b10001, BRIGHT};
    end else begin
      case (idx)
        5'd0:    b = 8'hC0;
        5'd1:    b = seg7(snap[7:4]);
        5'd3:    b = seg7(snap[3:0]);
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic [4:0]       byte_q, byte_d;
  logic [1:0]       txn_q, txn_d;
  logic             gap_q, gap_d;
  logic             pend_q, pend_d;
  logic [7:0]       snap_q, snap_d;
  logic             stb_q, stb_d;
  logic             sclk_q, sclk_d;
  logic             dio_q, dio_d;
  logic             busy_q, busy_d;

  logic       tick;
  logic       start;
  logic       differ;
  logic [4:0] last_idx;
  logic [7:0] cur_byte;
  logic [7:0] nxt_byte;

  assign tick     = (tick_q == TickMax);
  assign start    = tick && (state_q == StIdle) && pend_q;
  assign differ   = ({dig_hi, dig_lo} != snap_q);
  assign last_idx = (txn_q == 2'd1) ? 5'd16 : 5'd0;
  assign cur_byte = frame_byte(txn_q, byte_q, snap_q);
  assign nxt_byte = frame_byte(txn_q, byte_q + 5'd1, snap_q);

  always_comb begin
    tick_d = tick ? '0 : tick_q + TickW'(1);
    // Change detection runs every clk so an edit mid-frame queues exactly one more frame.
    pend_d = start ? 1'b0 : (pend_q | differ);
    snap_d = start ? {dig_hi, dig_lo} : snap_q;
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    txn_d   = txn_q;
    gap_d   = gap_q;
    stb_d   = stb_q;
    sclk_d  = sclk_q;
    dio_d   = dio_q;
    busy_d  = busy_q;
    if (tick) begin
      case (state_q)
        StIdle: begin
          if (pend_q) begin
            state_d = StStbLo;
            stb_d   = 1'b0;
            busy_d  = 1'b1;
            txn_d   = 2'd0;
            byte_d  = 5'd0;
            bit_d   = 3'd0;
          end
        end
        StStbLo: begin
          state_d = StShiftLo;
          sclk_d  = 1'b0;
          dio_d   = cur_byte[0];
        end
        StShiftLo: begin
          state_d = StShiftHi;
          sclk_d  = 1'b1;
        end
        StShiftHi: begin
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            state_d = StShiftLo;
            sclk_d  = 1'b0;
            dio_d   = cur_byte[bit_q + 3'd1];
          end else if (byte_q != last_idx) begin
            byte_d  = byte_q + 5'd1;
            bit_d   = 3'd0;
            state_d = StShiftLo;
            sclk_d  = 1'b0;
            dio_d   = nxt_byte[0];
          end else begin
            state_d = StStbHi;
          end
        end
        StStbHi: begin
          state_d = StGap;
          stb_d   = 1'b1;
          dio_d   = 1'b1;
          gap_d   = 1'b0;
        end
        StGap: begin
          if (!gap_q) begin
            gap_d = 1'b1;
          end else if (txn_q != 2'd2) begin
            txn_d   = txn_q + 2'd1;
            byte_d  = 5'd0;
            bit_d   = 3'd0;
            state_d = StStbLo;
            stb_d   = 1'b0;
          end else begin
            state_d = StIdle;
            // Keep busy asserted across the single idle tick of a back-to-back frame.
            busy_d  = pend_q | differ;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      tick_q  <= '0;
      state_q <= StIdle;
      bit_q   <= 3'd0;
      byte_q  <= 5'd0;
      txn_q   <= 2'd0;
      gap_q   <= 1'b0;
      pend_q  <= 1'b1;
      snap_q  <= 8'h00;
      stb_q   <= 1'b1;
      sclk_q  <= 1'b1;
      dio_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      txn_q   <= txn_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
      stb_q   <= stb_d;
      sclk_q  <= sclk_d;
      dio_q   <= dio_d;
      busy_q  <= busy_d;
    end
  end

  assign tm_stb = stb_q;
  assign tm_clk = sclk_q;
  assign tm_dio = dio_q;
  assign busy   = busy_q;

endmodule

// File: doc/tm1638_tx.md
Name: tm1638_tx

Overview:
Serial transmitter that drives a TM1638 LED&KEY display board from the two BCD digits produced by the mod-60 counter (tens, units). It encodes each digit to 7-segment and emits the complete TM1638 write frame on STB/CLK/DIO. A frame is sent after reset and again whenever the displayed value changes. The block sits between the counter and the board pins, on the fast system clock, not the 1 Hz clock.

Parameters:
CLK_DIV, 50, system clocks per tick; one serial bit = 2 ticks, range 2..1023
BRIGHT, 3'd7, brightness field of the display-control command (0..7)

Ports:
clk     in   1  system clock, rising edge
rs      in   1  asynchronous reset, active-low
dig_hi  in   4  tens digit, BCD
dig_lo  in   4  units digit, BCD
tm_stb  out  1  TM1638 STB, active-low frame strobe
tm_clk  out  1  TM1638 CLK, idle high
tm_dio  out  1  TM1638 DIO, write-only, idle high
busy    out  1  high while a frame is in progress

Behaviour:
- Reset (rs=0, async): tm_stb=1, tm_clk=1, tm_dio=1, busy=0, tick counter=0, state=IDLE, pending=1. On release, the first frame starts on the next tick.
- Tick: free-running counter 0..CLK_DIV-1. All state/output changes occur only on the clk edge where the counter wraps.
- Change detect: snapshot register holds the {dig_hi,dig_lo} last sent. If the inputs differ from the snapshot, pending=1; this is checked every clk, including during a frame. A frame start copies the inputs into the snapshot and clears pending. A change mid-frame therefore yields exactly one further frame after the current one.
- Segment encoding, active-high, bit0=a..bit6=g, bit7=dp=0: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Non-BCD values 10..15 map to 40 (dash).
- Frame = three transactions, T1, T2 and T3:
  - T1: byte 0x40 (write, auto-increment).
  - T2: byte 0xC0, then 16 data bytes: addr0=seg(dig_hi), addr2=seg(dig_lo), all other addresses 0x00 (digits 2..7 blank, all LEDs off).
  - T3: byte 0x88|BRIGHT (display on).
- Transaction timing, in ticks:
  - STB_LO: tm_stb=0 for 1 tick.
  - Per bit, LSB first: SHIFT_LO sets tm_clk=0 and tm_dio=bit for 1 tick; SHIFT_HI sets tm_clk=1 for 1 tick (the board samples on the rising edge).
  - Between bytes of the same transaction there is no extra tick.
  - STB_HI: after the last rising edge, 1 tick with tm_clk=1, then tm_stb=1 and tm_dio=1.
  - GAP: 2 ticks with STB high before the next transaction or IDLE.
- States: IDLE, STB_LO, SHIFT_LO, SHIFT_HI, STB_HI, GAP, with bit counter 0..7, byte counter 0..16 and transaction index 0..2.
  - IDLE to STB_LO when pending=1.
  - SHIFT_HI to SHIFT_LO while bits or bytes remain, otherwise to STB_HI.
  - GAP to STB_LO for the next transaction, or to IDLE after T3.
- Frame length: T1=20, T2=276, T3=20, total 316 ticks = 316*CLK_DIV clks.
  - busy=1 from the clk edge that leaves IDLE to the edge that re-enters IDLE.
  - Back-to-back frames: busy stays high; IDLE lasts 1 tick.
- tm_clk toggles only while tm_stb=0. tm_stb never falls with tm_clk low.
- Reset mid-frame: outputs return to idle immediately; the frame is abandoned and a full frame restarts after release.

Test Plan:
- CLK_DIV=4, digits 0/0, release reset. Serial decoder on tm_stb/tm_clk/tm_dio must capture 0x40 | 0xC0,3F,00,3F,00×13 | 0x8F. busy must be high for exactly 1264 clks, then tm_stb=tm_clk=tm_dio=1.
- After idle, set dig_hi=5, dig_lo=9. Exactly one new frame with addr0=6D, addr2=6F; no further frames while the inputs are held.
- Change the digits 3→4 (units) during T2 of a frame. The current frame finishes with the old value, then a second frame carries 66; busy stays high between them.
- dig_hi=4'hA, dig_lo=4'hF: addr0=40, addr2=40.
- Assert rs for 1 clk in mid-T2. Outputs go 1/1/1 asynchronously the same cycle; after release, a complete 316-tick frame is sent.
- Protocol checker over all tests: no tm_clk edge with tm_stb=1, tm_dio stable across every tm_clk rise, STB high ≥2 ticks between transactions; BRIGHT=3 gives a T3 byte of 0x8B.
